// File: rtl/alu_seq64_if.sv
// Request/response handshake bundle between the issue logic and the ALU sequencer.
// The issuer is the master; the sequencer is the slave.
interface alu_seq64_if #(
  parameter int unsigned W = 32
);
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_y;
  logic           rsp_c;
  logic           rsp_v;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_c, rsp_v
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_c, rsp_v
  );
endinterface

// File: rtl/alu_seq64.sv
// Issue-side sequencer for the 32-bit combinational ALU: runs 32/64-bit add/sub as one or two
// ALU passes, chaining the carry, and returns result plus carry/overflow flags.
module alu_seq64 #(
  parameter int unsigned W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq64_if.slave    bus,
  output logic [5:0]    alu_sel,
  output logic          alu_cin,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_y
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  localparam logic [5:0] SelAdd = 6'b000001;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic [W-1:0]   y_lo_q, y_lo_d;
  logic           carry_q, carry_d;
  logic [2*W-1:0] rsp_y_q, rsp_y_d;
  logic           rsp_c_q, rsp_c_d;
  logic           rsp_v_q, rsp_v_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [5:0]     alu_sel_q, alu_sel_d;
  logic           alu_cin_q, alu_cin_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;

  logic c_out;
  logic ovf;

  // The ALU has no carry output, so recover it from the unsigned wrap of the sum.
  assign c_out = (alu_y < alu_a_q) | (alu_cin_q & (alu_y == alu_a_q));
  assign ovf   = (alu_a_q[W-1] == alu_b_q[W-1]) & (alu_y[W-1] != alu_a_q[W-1]);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_lo_d  = y_lo_q;
    carry_d = carry_q;
    rsp_y_d = rsp_y_q;
    rsp_c_d = rsp_c_q;
    rsp_v_d = rsp_v_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          state_d = StLo;
        end
      end
      StLo: begin
        y_lo_d  = alu_y;
        carry_d = c_out;
        if (op_q[1]) begin
          rsp_y_d = {{W{1'b0}}, alu_y};
          rsp_c_d = c_out;
          rsp_v_d = ovf;
          state_d = StDone;
        end else begin
          state_d = StHi;
        end
      end
      StHi: begin
        rsp_y_d = {alu_y, y_lo_q};
        rsp_c_d = c_out;
        rsp_v_d = ovf;
        state_d = StDone;
      end
      StDone: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU drives are computed from the next state and registered, so they never glitch.
  always_comb begin
    alu_sel_d   = '0;
    alu_cin_d   = 1'b0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    rsp_valid_d = (state_d == StDone);
    if (state_d == StLo) begin
      alu_sel_d = SelAdd;
      alu_a_d   = a_d[W-1:0];
      alu_b_d   = b_d[W-1:0] ^ {W{op_d[0]}};
      alu_cin_d = op_d[0];
    end else if (state_d == StHi) begin
      alu_sel_d = SelAdd;
      alu_a_d   = a_d[2*W-1:W];
      alu_b_d   = b_d[2*W-1:W] ^ {W{op_d[0]}};
      alu_cin_d = carry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      y_lo_q      <= '0;
      carry_q     <= 1'b0;
      rsp_y_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      y_lo_q      <= y_lo_d;
      carry_q     <= carry_d;
      rsp_y_q     <= rsp_y_d;
      rsp_c_q     <= rsp_c_d;
      rsp_v_q     <= rsp_v_d;
      rsp_valid_q <= rsp_valid_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_v     = rsp_v_q;

  assign alu_sel = alu_sel_q;
  assign alu_cin = alu_cin_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;

endmodule

// File: tb/tb_alu_seq64.sv
// Directed and random checks of alu_seq64 against a behavioural ALU and a 64-bit reference
// model, with expected responses queued at issue and compared on delivery.
module tb_alu_seq64;

  typedef struct packed {
    logic [63:0] y;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  alu_sel;
  logic        alu_cin;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  int n_checks;
  int n_pass;
  int n_fail;
  exp_t sb[$];

  alu_seq64_if #(.W(32)) bus ();

  alu_seq64 #(.W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_sel (alu_sel),
    .alu_cin (alu_cin),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_y   (alu_y)
  );

  assign alu_y = (alu_sel == 6'b000001) ? (alu_a + alu_b + {31'b0, alu_cin}) : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0] s64;
    logic [32:0] s32;
    logic [63:0] bb;
    bb = op[0] ? ~b : b;
    if (op[1]) begin
      s32 = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + {32'b0, op[0]};
      e.y = {32'h0, s32[31:0]};
      e.c = s32[32];
      e.v = (a[31] == bb[31]) && (s32[31] != a[31]);
    end else begin
      s64 = {1'b0, a} + {1'b0, bb} + {64'b0, op[0]};
      e.y = s64[63:0];
      e.c = s64[64];
      e.v = (a[63] == bb[63]) && (s64[63] != a[63]);
    end
    return e;
  endfunction

  // Returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic ok;
    ok = 1'b0;
    sb.push_back(model(op, a, b));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    chk("issue_accept", {63'b0, ok}, 64'd1);
  endtask

  task automatic collect(input string tag);
    logic seen;
    exp_t e;
    seen = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, {63'b0, seen}, 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_y"}, bus.rsp_y, e.y);
      chk({tag, "_c"}, {63'b0, bus.rsp_c}, {63'b0, e.c});
      chk({tag, "_v"}, {63'b0, bus.rsp_v}, {63'b0, e.v});
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held_y;
    logic        seen;
    logic [1:0]  rop;
    logic [63:0] ra;
    logic [63:0] rb;

    n_checks      = 0;
    n_pass        = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    #12;
    chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_y", bus.rsp_y, 64'd0);
    chk("rst_alu_sel", {58'b0, alu_sel}, 64'd0);
    chk("rst_alu_a", {32'b0, alu_a}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD64 carry chain and latency.
    issue(2'b00, 64'h00000000_FFFFFFFF, 64'h1);
    chk("add64_lo_sel", {58'b0, alu_sel}, 64'd1);
    chk("add64_lo_a", {32'b0, alu_a}, 64'hFFFFFFFF);
    chk("add64_lo_cin", {63'b0, alu_cin}, 64'd0);
    @(posedge clk);
    #1;
    chk("add64_hi_cin", {63'b0, alu_cin}, 64'd1);
    chk("add64_hi_nvalid", {63'b0, bus.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("add64_lat", {63'b0, bus.rsp_valid}, 64'd1);
    chk("add64_y_const", bus.rsp_y, 64'h00000001_00000000);
    collect("add64");

    // SUB64 borrow through both halves.
    issue(2'b01, 64'h0, 64'h1);
    @(posedge clk);
    #1;
    chk("sub64_hi_b", {32'b0, alu_b}, 64'hFFFFFFFF);
    chk("sub64_hi_cin", {63'b0, alu_cin}, 64'd0);
    collect("sub64");

    // ADD32 overflow, one-edge latency.
    issue(2'b10, 64'h7FFFFFFF, 64'h1);
    @(posedge clk);
    #1;
    chk("add32_lat", {63'b0, bus.rsp_valid}, 64'd1);
    chk("add32_v_const", {63'b0, bus.rsp_v}, 64'd1);
    collect("add32");

    issue(2'b11, 64'h5, 64'h5);
    collect("sub32");

    // Backpressure with a second request pending.
    issue(2'b10, 64'hFFFF0000_12345678, 64'hAAAA0000_11111111);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_valid", {63'b0, seen}, 64'd1);
    held_y = bus.rsp_y;
    chk("bp_y", held_y, sb[0].y);
    sb.push_back(model(2'b00, 64'h1, 64'h2));
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 64'h1;
    bus.req_b     = 64'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'b0, bus.rsp_valid}, 64'd1);
      chk("bp_hold_y", bus.rsp_y, held_y);
      chk("bp_req_ready", {63'b0, bus.req_ready}, 64'd0);
    end
    void'(sb.pop_front());
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", {63'b0, bus.req_ready}, 64'd1);
    chk("bp_idle_nvalid", {63'b0, bus.rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("bp_second_accept", {63'b0, bus.req_ready}, 64'd0);
    chk("bp_second_lo", {58'b0, alu_sel}, 64'd1);
    collect("bp_second");

    // Reset during the HI pass of an ADD64.
    issue(2'b00, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_valid", {63'b0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_sel", {58'b0, alu_sel}, 64'd0);
    chk("mid_rst_a", {32'b0, alu_a}, 64'd0);
    chk("mid_rst_b", {32'b0, alu_b}, 64'd0);
    chk("mid_rst_ready", {63'b0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'b00, 64'h1, 64'h1);
    collect("post_rst");
    chk("post_rst_sb_empty", {32'b0, sb.size()}, 64'd0);

    // Random mix.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i == 0) begin
        ra = 64'h7FFFFFFF_FFFFFFFF;
        rb = 64'h1;
        rop = 2'b00;
      end
      if (i == 1) begin
        ra = 64'h80000000_00000000;
        rb = 64'h1;
        rop = 2'b01;
      end
      issue(rop, ra, rb);
      collect("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq64.md
Name: alu_seq64

Overview:
- Issue-side sequencer for the 32-bit combinational ALU. It drives the ALU's sel/cin/a/b inputs and consumes its y output.
- Accepts 32- or 64-bit add/subtract requests over a valid/ready handshake. A 64-bit operation runs as two ALU passes, with the carry chained from the low pass into the high pass.
- Returns the result with carry and signed-overflow flags over a second valid/ready handshake.
- Sits between the instruction issue logic and the ALU.

Parameters:
- W, 32, ALU word width; only 32 is supported. Request and response operands are 2*W bits wide.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_op  in  2  operation: 00 ADD64, 01 SUB64, 10 ADD32, 11 SUB32
- req_a  in  64  operand a; bits [63:32] are ignored for 32-bit ops
- req_b  in  64  operand b; bits [63:32] are ignored for 32-bit ops
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_y  out  64  result; bits [63:32] are zero for 32-bit ops
- rsp_c  out  1  carry out of the final pass (for SUB: 1 = no borrow)
- rsp_v  out  1  signed overflow of the final pass
- alu_sel  out  6  ALU function select
- alu_cin  out  1  ALU carry in
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_y  in  32  ALU result (combinational from the alu_* outputs)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; rsp_valid, rsp_y, rsp_c and rsp_v are all 0.
  - alu_sel = 6'b000000, alu_cin = 0, alu_a = 0, alu_b = 0.
  - req_ready = 1 while in IDLE, including during reset.
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready, register op, a and b, then go to LO.
  - LO: drive alu_sel = 6'b000001 (a + b + cin) and alu_a = a[31:0].
    - ADD: alu_b = b[31:0], alu_cin = 0.
    - SUB: alu_b = ~b[31:0], alu_cin = 1.
    - At the edge: y_lo <= alu_y and carry <= c_out. 64-bit ops go to HI; 32-bit ops go to DONE.
  - HI: alu_sel = 6'b000001, alu_a = a[63:32], alu_b = b[63:32] (inverted for SUB), alu_cin = carry from LO.
    - At the edge: rsp_y <= {alu_y, y_lo}, then go to DONE.
  - DONE: rsp_valid = 1, and all rsp_* outputs are held stable. On rsp_ready, go to IDLE.
    - A new request is not accepted in the same cycle, so the minimum spacing is 4 cycles for 64-bit ops and 3 for 32-bit ops.
- ALU drive outputs:
  - Driven from registered state and operands; glitch-free with respect to clk.
  - In IDLE and DONE: alu_sel = 0 and operands = 0.
- Carry out, computed by the sequencer (the ALU has no carry output):
  - c_out = (alu_y < alu_a) | (alu_cin & (alu_y == alu_a)), as an unsigned compare.
- Overflow, final pass only:
  - rsp_v = (alu_a[31] == alu_b[31]) & (alu_y[31] != alu_a[31]), where alu_b is the driven (possibly inverted) operand.
- Flag capture: rsp_c and rsp_v are captured at the same edge as the final y.
  - For 32-bit ops: rsp_y <= {32'h0, alu_y} at the end of LO.
- Latency, counting from the accepting edge E0:
  - rsp_valid is high after E0+2 for 64-bit ops and after E0+1 for 32-bit ops.
- Boundary conditions:
  - req_valid while not in IDLE: ignored (req_ready = 0). The requester must hold the request.
  - rsp_ready while not in DONE: ignored.
  - rsp_ready held low: stay in DONE indefinitely with outputs unchanged.
  - Undefined or X req_op: cannot occur, since all 4 codes are defined.
  - rst_n asserted in any state aborts the operation immediately. No response is produced, and IDLE is entered at reset release.

Test Plan:
- ADD64, a = 0x00000000_FFFFFFFF, b = 0x1 → rsp_y = 0x00000001_00000000, rsp_c = 0, rsp_v = 0. The LO pass carries into HI with alu_cin = 1. rsp_valid is asserted 2 edges after accept.
- SUB64, a = 0, b = 1 → rsp_y = 0xFFFFFFFF_FFFFFFFF, rsp_c = 0 (borrow), rsp_v = 0. HI pass drives alu_b = 0xFFFFFFFF, alu_cin = 0.
- ADD32, a = 0x7FFFFFFF, b = 1 → rsp_y = 0x00000000_80000000, rsp_c = 0, rsp_v = 1, valid 1 edge after accept. SUB32, a = 5, b = 5 → rsp_y = 0, rsp_c = 1, rsp_v = 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid with a second request pending → rsp_* stable, req_ready = 0. Raise rsp_ready → IDLE on the next edge, and the second request is accepted one cycle later.
- Reset mid-operation: drop rst_n during HI of an ADD64 → rsp_valid = 0 and alu_* = 0 asynchronously, req_ready = 1. After release, ADD64 0x1 + 0x1 → rsp_y = 0x2.
- Bench connects a behavioural ALU model computing y = a + b + cin for sel = 6'b000001. Randomised 64-bit ADD/SUB results are compared against a 64-bit reference sum, carry and overflow.
